// File: rtl/fft_frame_sequencer.sv
// Frame sequencer around the parallel FFT core: collect N samples, wait FFT_LATENCY+1 cycles, then stream N bins.
// First bin is valid FFT_LATENCY+1 cycles after the last input accept; m_ready low holds the bin, and s_ready is low outside COLLECT.
module fft_frame_sequencer #(
  parameter int N           = 8,
  parameter int W           = 12,
  parameter int FFT_LATENCY = 4,
  parameter int FRAME_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [W-1:0]           s_real,
  input  logic [W-1:0]           s_imag,
  output logic [N*W-1:0]         fft_x_real,
  output logic [N*W-1:0]         fft_x_imag,
  input  logic [N*W-1:0]         fft_y_real,
  input  logic [N*W-1:0]         fft_y_imag,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [W-1:0]           m_real,
  output logic [W-1:0]           m_imag,
  output logic [$clog2(N)-1:0]   m_index,
  output logic                   m_last,
  output logic                   frame_done,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic                   busy
);

  localparam int IDX_W = $clog2(N);
  localparam int LAT_W = (FFT_LATENCY > 1) ? $clog2(FFT_LATENCY) : 1;

  typedef enum logic [1:0] {COLLECT, WAIT, CAPTURE, DRAIN} state_e;

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       wr_idx_q, wr_idx_d;
  logic [IDX_W-1:0]       rd_idx_q, rd_idx_d;
  logic [LAT_W-1:0]       wait_cnt_q, wait_cnt_d;
  logic [N*W-1:0]         x_real_q, x_real_d;
  logic [N*W-1:0]         x_imag_q, x_imag_d;
  logic [N*W-1:0]         out_real_q, out_real_d;
  logic [N*W-1:0]         out_imag_q, out_imag_d;
  logic                   frame_done_q, frame_done_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= COLLECT;
      wr_idx_q     <= '0;
      rd_idx_q     <= '0;
      wait_cnt_q   <= '0;
      x_real_q     <= '0;
      x_imag_q     <= '0;
      out_real_q   <= '0;
      out_imag_q   <= '0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      wr_idx_q     <= wr_idx_d;
      rd_idx_q     <= rd_idx_d;
      wait_cnt_q   <= wait_cnt_d;
      x_real_q     <= x_real_d;
      x_imag_q     <= x_imag_d;
      out_real_q   <= out_real_d;
      out_imag_q   <= out_imag_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    wr_idx_d     = wr_idx_q;
    rd_idx_d     = rd_idx_q;
    wait_cnt_d   = wait_cnt_q;
    x_real_d     = x_real_q;
    x_imag_d     = x_imag_q;
    out_real_d   = out_real_q;
    out_imag_d   = out_imag_q;
    frame_done_d = 1'b0;
    frame_cnt_d  = frame_cnt_q;

    case (state_q)
      COLLECT: begin
        if (s_valid) begin
          x_real_d[wr_idx_q*W +: W] = s_real;
          x_imag_d[wr_idx_q*W +: W] = s_imag;
          if (wr_idx_q == IDX_W'(N-1)) begin
            wr_idx_d   = '0;
            wait_cnt_d = '0;
            state_d    = WAIT;
          end else begin
            wr_idx_d = wr_idx_q + 1'b1;
          end
        end
      end
      // The core has no valid; its output is trusted only after the full pipeline depth.
      WAIT: begin
        if (wait_cnt_q == LAT_W'(FFT_LATENCY-1)) begin
          state_d = CAPTURE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      CAPTURE: begin
        out_real_d = fft_y_real;
        out_imag_d = fft_y_imag;
        rd_idx_d   = '0;
        state_d    = DRAIN;
      end
      DRAIN: begin
        if (m_ready) begin
          if (rd_idx_q == IDX_W'(N-1)) begin
            rd_idx_d     = '0;
            frame_done_d = 1'b1;
            frame_cnt_d  = frame_cnt_q + 1'b1;
            state_d      = COLLECT;
          end else begin
            rd_idx_d = rd_idx_q + 1'b1;
          end
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  assign s_ready    = (state_q == COLLECT);
  assign m_valid    = (state_q == DRAIN);
  assign m_real     = m_valid ? out_real_q[rd_idx_q*W +: W] : '0;
  assign m_imag     = m_valid ? out_imag_q[rd_idx_q*W +: W] : '0;
  assign m_index    = rd_idx_q;
  assign m_last     = m_valid && (rd_idx_q == IDX_W'(N-1));
  assign fft_x_real = x_real_q;
  assign fft_x_imag = x_imag_q;
  assign frame_done = frame_done_q;
  assign frame_cnt  = frame_cnt_q;
  assign busy       = (state_q != COLLECT) || (wr_idx_q != '0);

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed bench for fft_frame_sequencer with a behavioural 4-stage DFT core model on the x/y ports.
module tb_fft_frame_sequencer;
  localparam int N   = 8;
  localparam int W   = 12;
  localparam int LAT = 4;
  localparam int CW  = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           s_valid = 1'b0;
  logic           s_ready;
  logic [W-1:0]   s_real = '0;
  logic [W-1:0]   s_imag = '0;
  logic [N*W-1:0] fft_x_real, fft_x_imag, fft_y_real, fft_y_imag;
  logic           m_valid;
  logic           m_ready = 1'b1;
  logic [W-1:0]   m_real, m_imag;
  logic [2:0]     m_index;
  logic           m_last, frame_done, busy;
  logic [CW-1:0]  frame_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int e0 = 0;
  int exp_cnt = 0;

  fft_frame_sequencer #(.N(N), .W(W), .FFT_LATENCY(LAT), .FRAME_CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_real(s_real), .s_imag(s_imag),
    .fft_x_real(fft_x_real), .fft_x_imag(fft_x_imag),
    .fft_y_real(fft_y_real), .fft_y_imag(fft_y_imag),
    .m_valid(m_valid), .m_ready(m_ready), .m_real(m_real), .m_imag(m_imag),
    .m_index(m_index), .m_last(m_last), .frame_done(frame_done),
    .frame_cnt(frame_cnt), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Unscaled DFT, Q3.9 in, Q5.7 out (>>2), twiddles Q1.14.
  function automatic logic [N*W-1:0] dft(input logic [N*W-1:0] xr, input logic [N*W-1:0] xi, input bit im);
    int c [8];
    logic [N*W-1:0] res;
    c = '{16384, 11585, 0, -11585, -16384, -11585, 0, 11585};
    res = '0;
    for (int k = 0; k < N; k++) begin
      int acc;
      acc = 0;
      for (int n = 0; n < N; n++) begin
        int m, a, b;
        m = (k * n) % 8;
        a = int'($signed(xr[n*W +: W]));
        b = int'($signed(xi[n*W +: W]));
        if (im) acc += b * c[m] - a * c[(m + 6) % 8];
        else    acc += a * c[m] + b * c[(m + 6) % 8];
      end
      acc = acc >>> 16;
      res[k*W +: W] = acc[W-1:0];
    end
    return res;
  endfunction

  logic [N*W-1:0] pr [LAT];
  logic [N*W-1:0] pi [LAT];
  always @(posedge clk) begin
    pr[0] <= dft(fft_x_real, fft_x_imag, 1'b0);
    pi[0] <= dft(fft_x_real, fft_x_imag, 1'b1);
    for (int i = 1; i < LAT; i++) begin
      pr[i] <= pr[i-1];
      pi[i] <= pi[i-1];
    end
  end
  assign fft_y_real = pr[LAT-1];
  assign fft_y_imag = pi[LAT-1];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Feeds one frame; gaps applies the 1,0,0,1 s_valid pattern. Records e0 at the final accept.
  task automatic feed(input logic [N*W-1:0] xr, input logic [N*W-1:0] xi, input bit gaps);
    int n, p;
    bit acc;
    n = 0;
    p = 0;
    while (n < N && p < 200) begin
      s_valid = gaps ? ((p % 4 == 0) || (p % 4 == 3)) : 1'b1;
      s_real  = xr[n*W +: W];
      s_imag  = xi[n*W +: W];
      acc     = s_valid && s_ready;
      step();
      p++;
      if (acc) begin
        n++;
        if (n == N) e0 = cyc;
      end
    end
    s_valid = 1'b0;
    check("feed_accepts", n, N);
  endtask

  task automatic wait_valid(output int lat);
    int t;
    t = 0;
    while (!m_valid && t < 50) begin
      step();
      t++;
    end
    check("wait_m_valid", m_valid, 1'b1);
    lat = cyc - e0;
  endtask

  task automatic drain(input logic [N*W-1:0] er, input logic [N*W-1:0] ei, input int st2, input int st7);
    for (int k = 0; k < N; k++) begin
      int st;
      st = (k == 2) ? st2 : ((k == 7) ? st7 : 0);
      check("bin_valid", m_valid, 1'b1);
      check("bin_index", m_index, k);
      check("bin_real", m_real, er[k*W +: W]);
      check("bin_imag", m_imag, ei[k*W +: W]);
      check("bin_last", m_last, (k == N-1));
      if (st > 0) begin
        m_ready = 1'b0;
        for (int s = 0; s < st; s++) begin
          step();
          check("stall_valid", m_valid, 1'b1);
          check("stall_index", m_index, k);
          check("stall_real", m_real, er[k*W +: W]);
          check("stall_done", frame_done, 1'b0);
        end
        m_ready = 1'b1;
      end
      if (k == N-1) check("cnt_before_done", frame_cnt, exp_cnt[CW-1:0]);
      step();
      if (k < N-1) begin
        check("no_early_done", frame_done, 1'b0);
      end else begin
        exp_cnt = (exp_cnt + 1) % (1 << CW);
        check("frame_done", frame_done, 1'b1);
        check("frame_cnt", frame_cnt, exp_cnt[CW-1:0]);
        check("valid_drop", m_valid, 1'b0);
        check("ready_back", s_ready, 1'b1);
      end
    end
  endtask

  initial begin
    logic [N*W-1:0] xr, xi, xs;
    logic [W-1:0] v;
    int lat, t;

    step();
    step();
    rst_n = 1'b1;
    check("rst_s_ready", s_ready, 1'b1);
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_fft_x", {fft_x_real, fft_x_imag}, 0);

    // Impulse: every bin 1.0 in Q5.7.
    xr = '0;
    xr[W-1:0] = 12'h200;
    xi = '0;
    feed(xr, xi, 1'b0);
    wait_valid(lat);
    check("impulse_latency", lat, LAT + 1);
    drain({N{12'h080}}, '0, 0, 0);

    // Gapped input plus output backpressure.
    for (int k = 0; k < N; k++) xr[k*W +: W] = W'(k + 1);
    xi = '0;
    feed(xr, xi, 1'b1);
    check("gaps_slots", fft_x_real, 96'h008_007_006_005_004_003_002_001);
    check("gaps_busy", busy, 1'b1);
    wait_valid(lat);
    check("gaps_latency", lat, LAT + 1);
    drain(dft(xr, xi, 1'b0), dft(xr, xi, 1'b1), 3, 1);

    // s_valid held high with changing data outside COLLECT.
    for (int k = 0; k < N; k++) begin
      xr[k*W +: W] = W'(12'h100 + 17 * k);
      xi[k*W +: W] = W'(12'hF80 + 9 * k);
    end
    feed(xr, xi, 1'b0);
    xs = fft_x_real;
    s_valid = 1'b1;
    t = 0;
    while (!frame_done && t < 40) begin
      check("illegal_s_ready", s_ready, 1'b0);
      check("illegal_x_hold", fft_x_real, xs);
      s_real = W'(12'h300 + t);
      step();
      t++;
    end
    exp_cnt = 3;
    check("illegal_done_seen", frame_done, 1'b1);
    check("illegal_ready_back", s_ready, 1'b1);
    check("illegal_frame_cnt", frame_cnt, 3);
    v = s_real;
    for (int k = 0; k < N; k++) begin
      xr[k*W +: W] = W'(12'h040 + 3 * k);
      xi[k*W +: W] = W'(12'h020 - 5 * k);
    end
    xr[W-1:0] = v;
    xi[W-1:0] = '0;
    s_imag = '0;
    feed(xr, xi, 1'b0);
    check("illegal_first_sample", fft_x_real[W-1:0], v);

    // Reset while bin 4 is presented.
    wait_valid(lat);
    t = 0;
    while (m_index != 3'd4 && t < 20) begin
      step();
      t++;
    end
    check("reach_bin4", m_index, 4);
    rst_n = 1'b0;
    #1;
    check("rstmid_m_valid", m_valid, 1'b0);
    check("rstmid_outputs", {m_real, m_imag, m_index, m_last, frame_done}, 0);
    check("rstmid_ready_busy", {s_ready, busy}, 2'b10);
    check("rstmid_cnt", frame_cnt, 0);
    check("rstmid_fft_x", {fft_x_real, fft_x_imag}, 0);
    step();
    step();
    rst_n = 1'b1;
    step();
    check("post_rst_no_output", m_valid, 1'b0);
    exp_cnt = 0;

    // Five back-to-back frames: frame_cnt 1, 2, 3, 0, 1.
    for (int f = 0; f < 5; f++) begin
      for (int k = 0; k < N; k++) begin
        xr[k*W +: W] = W'(37 * f + 29 * k);
        xi[k*W +: W] = W'(11 * f - 13 * k);
      end
      feed(xr, xi, 1'b0);
      wait_valid(lat);
      check("wrap_latency", lat, LAT + 1);
      drain(dft(xr, xi, 1'b0), dft(xr, xi, 1'b1), 0, 0);
    end
    check("wrap_final_cnt", frame_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
